// File: rtl/pref_issue_queue.sv
//------------------------------------------------------------------------------
// pref_issue_queue : line-aligns up to three prefetch candidates per cycle,
//   drops duplicates against queued/recently issued lines, and issues them
//   one per cycle over a valid/ready port. Optional stats: PREF_ISSUE_QUEUE_STATS_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pref_issue_queue #(
  parameter int QUEUE_DEPTH  = 8,
  parameter int FILTER_DEPTH = 16,
  parameter int LINE_BITS    = 6,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      pref_addr1_i,
  input  logic             pref_valid1_i,
  input  logic [63:0]      pref_addr2_i,
  input  logic             pref_valid2_i,
  input  logic [63:0]      pref_addr3_i,
  input  logic             pref_valid3_i,
  output logic [63:0]      req_addr_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] filt_cnt_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [63:0] LINE_MASK = ~((64'd1 << LINE_BITS) - 64'd1);

  logic [63:0]             q_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  q_vld;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic [63:0]             f_mem [FILTER_DEPTH];
  logic [FILTER_DEPTH-1:0] f_vld;
  logic [FW-1:0]           f_ptr;

  logic [63:0]   line [3];
  logic [2:0]    cand_vld;
  logic [2:0]    hit_store;
  logic [2:0]    dup;
  logic [2:0]    enq;
  logic [PW-1:0] wpos [3];
  logic [1:0]    npush;
  logic          pop;
  logic [CW:0]   free;

  assign line[0]  = pref_addr1_i & LINE_MASK;
  assign line[1]  = pref_addr2_i & LINE_MASK;
  assign line[2]  = pref_addr3_i & LINE_MASK;
  assign cand_vld = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

  assign req_valid_o = (count != '0);
  assign req_addr_o  = req_valid_o ? q_mem[rd_ptr] : '0;
  assign pop         = req_valid_o & req_ready_i;
  assign free        = (CW+1)'(QUEUE_DEPTH) - {1'b0, count} + (CW+1)'(pop);

  // The head entry still counts as queued while it is being popped.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      hit_store[k] = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (q_vld[i] && q_mem[i] == line[k]) hit_store[k] = 1'b1;
      for (int j = 0; j < FILTER_DEPTH; j++)
        if (f_vld[j] && f_mem[j] == line[k]) hit_store[k] = 1'b1;
    end
  end

  // Slots are resolved in order so lower slots win both dedup and space.
  always_comb begin
    npush = '0;
    dup   = '0;
    enq   = '0;
    for (int k = 0; k < 3; k++) begin
      wpos[k] = wr_ptr + PW'(npush);
      dup[k]  = cand_vld[k] & hit_store[k];
      for (int p = 0; p < k; p++)
        if (enq[p] && line[p] == line[k]) dup[k] = cand_vld[k];
      enq[k] = cand_vld[k] & ~dup[k] & ((CW+1)'(npush) < free);
      npush  = npush + 2'(enq[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld  <= '0;
      f_vld  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      f_ptr  <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        f_vld[f_ptr]  <= 1'b1;
        f_ptr         <= (f_ptr == FW'(FILTER_DEPTH-1)) ? '0 : f_ptr + 1'b1;
      end
      for (int k = 0; k < 3; k++)
        if (enq[k]) q_vld[wpos[k]] <= 1'b1;
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(npush);
      count  <= count + CW'(npush) - CW'(pop);
    end
  end

  // Payload storage needs no reset: validity is carried by q_vld/f_vld.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (pop) f_mem[f_ptr] <= q_mem[rd_ptr];
      for (int k = 0; k < 3; k++)
        if (enq[k]) q_mem[wpos[k]] <= line[k];
    end
  end

`ifdef PREF_ISSUE_QUEUE_STATS_EN
  logic [1:0]       n_drop;
  logic [1:0]       n_filt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] filt_cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    n_drop = '0;
    n_filt = '0;
    for (int k = 0; k < 3; k++) begin
      n_filt = n_filt + 2'(dup[k]);
      n_drop = n_drop + 2'(cand_vld[k] & ~dup[k] & ~enq[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      filt_cnt <= '0;
    end else begin
      drop_cnt <= sat_add(drop_cnt, n_drop);
      filt_cnt <= sat_add(filt_cnt, n_filt);
    end
  end

  assign drop_cnt_o = drop_cnt;
  assign filt_cnt_o = filt_cnt;
`else
  assign drop_cnt_o = '0;
  assign filt_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pref_issue_queue.md
Name: pref_issue_queue

Overview:
- Sits directly downstream of ip_stride.
- Each cycle it takes up to three prefetch candidates (slots 1..3), aligns them to cache lines and drops duplicates against queued and recently issued lines.
- Surviving candidates are buffered in a FIFO and issued one per cycle to the memory-side request port over a valid/ready handshake.
- Keeps the stream of stride predictions from flooding the memory interface with repeat or overflow requests.

Parameters:
- QUEUE_DEPTH, 8, FIFO entries; power of two, >= 4.
- FILTER_DEPTH, 16, recently-issued line table entries; >= 1.
- LINE_BITS, 6, log2 of line size in bytes; low LINE_BITS address bits are cleared.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pref_addr1_i  in  64  slot 1 candidate byte address.
- pref_valid1_i  in  1  slot 1 candidate valid.
- pref_addr2_i  in  64  slot 2 candidate byte address.
- pref_valid2_i  in  1  slot 2 candidate valid.
- pref_addr3_i  in  64  slot 3 candidate byte address.
- pref_valid3_i  in  1  slot 3 candidate valid.
- req_addr_o  out  64  line-aligned head-of-queue address.
- req_valid_o  out  1  queue non-empty.
- req_ready_i  in  1  memory side accepts the request.
- drop_cnt_o  out  CNT_W  candidates lost to a full queue.
- filt_cnt_o  out  CNT_W  candidates removed as duplicates.

Behaviour:
- Reset (rst=1 at posedge):
  - Queue becomes empty; all filter entries become invalid; counters go to 0.
  - req_valid_o=0 and req_addr_o=0 in the following cycle.
  - Reset overrides any same-cycle push or pop; a pending request is discarded.
- Line address: line(a) = a with bits [LINE_BITS-1:0] forced to 0. All compares and all stored values use line addresses.
- Pop:
  - Occurs when req_valid_o & req_ready_i.
  - req_addr_o is the registered head entry.
  - req_valid_o = (count != 0).
  - req_addr_o must hold stable while req_valid_o=1 and req_ready_i=0.
  - req_addr_o is 0 when the queue is empty.
- Filter update:
  - On pop, the popped line is written to the filter table at the filter write pointer, that entry is marked valid, and the pointer wraps modulo FILTER_DEPTH.
  - Replacement is FIFO; the oldest entry is overwritten.
- Candidate processing order: slot 1, then slot 2, then slot 3. All decisions are made combinationally in the cycle the candidate is presented.
- A valid candidate is a duplicate if its line equals any of:
  - a valid queue entry (including the entry being popped this cycle);
  - a valid filter entry;
  - a lower-numbered slot candidate accepted this cycle.
- A duplicate is not enqueued and increments filt_cnt_o.
- Free space: free = QUEUE_DEPTH - count + (pop ? 1 : 0).
- A non-duplicate candidate is enqueued if free space remains after earlier slots this cycle; otherwise it is dropped and increments drop_cnt_o.
- Lower slots always have priority for space.
- Counters: both may increase by up to 3 per cycle. They saturate at 2^CNT_W-1 and never wrap.
- Latency:
  - A candidate accepted at posedge N into an empty queue gives req_valid_o=1 with its address after posedge N.
  - It is therefore visible for the whole of cycle N+1 and poppable at posedge N+1.
  - There is no bypass path.
- Count update: count_next = count + pushes - pop. It never exceeds QUEUE_DEPTH and never goes below 0.
- Pointer wrap: read and write pointers wrap at QUEUE_DEPTH. Ordering is strict FIFO across the wrap.
- Invalid slots (valid=0) are ignored entirely; their addresses are don't-care.

Optional Feature:
- Macro: PREF_ISSUE_QUEUE_STATS_EN.
  - Defined: drop_cnt_o and filt_cnt_o operate as described above.
  - Undefined: counter registers are not built; drop_cnt_o and filt_cnt_o are tied to 0.
- Queue, filter and handshake behaviour is identical in both builds.

Test Plan:
- Single push/pop:
  - Stimulus: reset, hold req_ready_i=1; present slot1 = 0x1007 for one cycle.
  - Response: the next cycle shows req_valid_o=1 and req_addr_o=0x1000; req_valid_o=0 the cycle after.
- Same-cycle dedup:
  - Stimulus: slot1 = 0x2000, slot2 = 0x203F, slot3 = 0x2040 with req_ready_i=0.
  - Response: queue holds 0x2000 then 0x2040; filt_cnt_o=1.
- Overflow priority:
  - Stimulus: req_ready_i=0; fill 7 distinct lines; then present 3 new distinct lines in one cycle.
  - Response: only slot1 is enqueued; drop_cnt_o=2; req_valid_o stays 1 and req_addr_o holds the first line.
- Filter hit after issue:
  - Stimulus: push and pop 0x4000; then re-present 0x4010.
  - Response: not enqueued; filt_cnt_o increments.
  - Follow-up: after 16 further distinct pops, 0x4000 is accepted again.
- Backpressure, simultaneous push/pop and wrap:
  - Stimulus: with the queue full (8 entries), assert req_ready_i=1 and push one new line in the same cycle; then stream 20 distinct lines with ready toggling.
  - Response: the same-cycle push is accepted; issue order equals accept order; no loss or duplication across the pointer wrap.
- Reset mid-operation:
  - Stimulus: with 5 queued entries and counters non-zero, assert rst for one cycle.
  - Response: the next cycle shows req_valid_o=0, req_addr_o=0 and counters 0; previously filtered lines are accepted again.
